// File: rtl/ecc_mul_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ecc_mul_io_bridge
// Brief    : Deserialises Px/Py/k for the ECC scalar multiplier, launches it,
//            and serialises the captured Rx/Ry result onto the output stream.
// Revision : 1.0
// ============================================================================
module ecc_mul_io_bridge #(
    parameter int DATA_WIDTH = 256,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BUS_WIDTH-1:0]  s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [BUS_WIDTH-1:0]  m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] mul_Px,
    output logic [DATA_WIDTH-1:0] mul_Py,
    output logic [DATA_WIDTH-1:0] mul_k,
    output logic                  mul_in_valid,
    input  logic [DATA_WIDTH-1:0] mul_Rx,
    input  logic [DATA_WIDTH-1:0] mul_Ry,
    input  logic                  mul_out_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int WORDS  = DATA_WIDTH / BUS_WIDTH;
    localparam int IN_CW  = $clog2(3 * WORDS);
    localparam int OUT_CW = $clog2(2 * WORDS);
    localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(3 * WORDS - 1);
    localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(2 * WORDS - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [IN_CW-1:0]            r_in_cnt;
    logic [IN_CW-1:0]            w_in_cnt_next;
    logic [OUT_CW-1:0]           r_out_cnt;
    logic [OUT_CW-1:0]           w_out_cnt_next;
    logic [3*DATA_WIDTH-1:0]     r_operands;
    logic [2*DATA_WIDTH-1:0]     r_result;
    logic [2*DATA_WIDTH-1:0]     w_res_src;
    logic [BUS_WIDTH-1:0]        w_m_data_next;
    logic                        w_m_last_next;
    logic                        w_frame_err_next;

    logic w_accept;
    logic w_in_final;
    logic w_capture;
    logic w_out_fire;

    assign w_accept   = (r_state == S_LOAD) && s_valid && s_ready;
    assign w_in_final = (r_in_cnt == IN_LAST);
    assign w_capture  = (r_state == S_WAIT) && mul_out_valid;
    assign w_out_fire = m_valid && m_ready;

    assign mul_Px = r_operands[0            +: DATA_WIDTH];
    assign mul_Py = r_operands[DATA_WIDTH   +: DATA_WIDTH];
    assign mul_k  = r_operands[2*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        w_state_next     = r_state;
        w_in_cnt_next    = r_in_cnt;
        w_out_cnt_next   = r_out_cnt;
        w_frame_err_next = 1'b0;
        case (r_state)
            S_LOAD: begin
                if (w_accept) begin
                    // A last flag on the wrong word (early or missing) discards the frame
                    if (s_last != w_in_final) begin
                        w_frame_err_next = 1'b1;
                        w_in_cnt_next    = '0;
                    end else if (w_in_final) begin
                        w_state_next  = S_START;
                        w_in_cnt_next = '0;
                    end else begin
                        w_in_cnt_next = r_in_cnt + 1'b1;
                    end
                end
            end
            S_START: w_state_next = S_WAIT;
            S_WAIT: begin
                if (mul_out_valid) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_fire) begin
                    if (r_out_cnt == OUT_LAST) begin
                        w_state_next   = S_LOAD;
                        w_out_cnt_next = '0;
                    end else begin
                        w_out_cnt_next = r_out_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    // The first output word is taken straight from the multiplier bus on capture
    always_comb begin
        w_res_src     = w_capture ? {mul_Ry, mul_Rx} : r_result;
        w_m_data_next = '0;
        if (w_state_next == S_DRAIN) begin
            for (int i = 0; i < 2 * WORDS; i++) begin
                if (w_out_cnt_next == OUT_CW'(i)) begin
                    w_m_data_next = w_res_src[i*BUS_WIDTH +: BUS_WIDTH];
                end
            end
        end
        w_m_last_next = (w_state_next == S_DRAIN) && (w_out_cnt_next == OUT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_LOAD;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_operands   <= '0;
            r_result     <= '0;
            s_ready      <= 1'b0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_data       <= '0;
            mul_in_valid <= 1'b0;
            frame_err    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_in_cnt     <= w_in_cnt_next;
            r_out_cnt    <= w_out_cnt_next;
            s_ready      <= (w_state_next == S_LOAD);
            m_valid      <= (w_state_next == S_DRAIN);
            m_last       <= w_m_last_next;
            m_data       <= w_m_data_next;
            mul_in_valid <= (w_state_next == S_START);
            frame_err    <= w_frame_err_next;
            busy         <= (w_state_next != S_LOAD);
            if (w_accept) begin
                for (int i = 0; i < 3 * WORDS; i++) begin
                    if (r_in_cnt == IN_CW'(i)) begin
                        r_operands[i*BUS_WIDTH +: BUS_WIDTH] <= s_data;
                    end
                end
            end
            if (w_capture) begin
                r_result <= {mul_Ry, mul_Rx};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecc_mul_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_mul_io_bridge
// Brief    : Directed bench with a frame/queue reference model and stub multiplier.
// Revision : 1.0
// ============================================================================
module tb_ecc_mul_io_bridge;

    localparam int DW = 256;
    localparam int BW = 32;
    localparam int W  = DW / BW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [BW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic          s_ready;
    logic [BW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b1;
    logic [DW-1:0] mul_Px, mul_Py, mul_k;
    logic          mul_in_valid;
    logic [DW-1:0] mul_Rx, mul_Ry;
    logic          mul_out_valid;
    logic          frame_err;
    logic          busy;

    ecc_mul_io_bridge #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .mul_Px(mul_Px), .mul_Py(mul_Py), .mul_k(mul_k), .mul_in_valid(mul_in_valid),
        .mul_Rx(mul_Rx), .mul_Ry(mul_Ry), .mul_out_valid(mul_out_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Stub multiplier: 12-cycle latency, Rx = Px + 1, Ry = Py ^ k
    int            stub_lat = 0;
    logic          stub_valid = 1'b0;
    logic          spur = 1'b0;
    logic [DW-1:0] stub_px = '0, stub_py = '0, stub_k = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_lat   = 0;
            stub_valid = 1'b0;
        end else begin
            stub_valid = 1'b0;
            if (stub_lat > 0) begin
                stub_lat--;
                if (stub_lat == 0) stub_valid = 1'b1;
            end
            if (mul_in_valid) begin
                stub_lat = 12;
                stub_px  = mul_Px;
                stub_py  = mul_Py;
                stub_k   = mul_k;
            end
        end
    end

    assign mul_out_valid = stub_valid | spur;
    assign mul_Rx = stub_valid ? stub_px + 256'd1 : {8{32'hDEADBEEF}};
    assign mul_Ry = stub_valid ? stub_py ^ stub_k : {8{32'hBADC0FFE}};

    // Reference model: frame words, operation-in-flight flag, expected output word queue
    logic [BW-1:0] fw [0:3*W-1];
    int            cnt = 0;
    bit            in_flight = 1'b0;
    logic          exp_sready = 1'b0, exp_err = 1'b0, exp_start = 1'b0;
    logic          nerr, nstart;
    logic [DW-1:0] exp_px = '0, exp_py = '0, exp_k = '0, m_rx, m_ry;
    logic [BW-1:0] outq [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight  = 1'b0;
            outq.delete();
            cnt        = 0;
            exp_sready = 1'b0;
            exp_err    = 1'b0;
            exp_start  = 1'b0;
        end else begin
            nerr   = 1'b0;
            nstart = 1'b0;
            if (outq.size() > 0 && m_ready) begin
                void'(outq.pop_front());
                if (outq.size() == 0) in_flight = 1'b0;
            end
            if (in_flight && !exp_start && outq.size() == 0 && mul_out_valid) begin
                m_rx = exp_px + 256'd1;
                m_ry = exp_py ^ exp_k;
                for (int i = 0; i < W; i++) outq.push_back(m_rx[i*BW +: BW]);
                for (int i = 0; i < W; i++) outq.push_back(m_ry[i*BW +: BW]);
            end
            if (exp_sready && s_valid) begin
                fw[cnt] = s_data;
                if (s_last != (cnt == 3*W-1)) begin
                    nerr = 1'b1;
                    cnt  = 0;
                end else if (cnt == 3*W-1) begin
                    for (int i = 0; i < W; i++) begin
                        exp_px[i*BW +: BW] = fw[i];
                        exp_py[i*BW +: BW] = fw[W+i];
                        exp_k[i*BW +: BW]  = fw[2*W+i];
                    end
                    in_flight = 1'b1;
                    nstart    = 1'b1;
                    cnt       = 0;
                end else begin
                    cnt++;
                end
            end
            exp_err    = nerr;
            exp_start  = nstart;
            exp_sready = !in_flight;
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            chk("rst_s_ready", s_ready, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_mul_in_valid", mul_in_valid, 0);
            chk("rst_frame_err", frame_err, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mul_Px", mul_Px, 0);
        end else begin
            chk("s_ready", s_ready, exp_sready);
            chk("busy", busy, in_flight);
            chk("frame_err", frame_err, exp_err);
            chk("mul_in_valid", mul_in_valid, exp_start);
            chk("m_valid", m_valid, outq.size() > 0);
            if (outq.size() > 0) begin
                chk("m_data", m_data, outq[0]);
                chk("m_last", m_last, outq.size() == 1);
            end else begin
                chk("m_last_idle", m_last, 0);
            end
            if (in_flight) begin
                chk("mul_Px", mul_Px, exp_px);
                chk("mul_Py", mul_Py, exp_py);
                chk("mul_k", mul_k, exp_k);
            end
        end
    end

    // Event log used by the hand-computed literal checks
    int            start_cnt = 0;
    int            err_cnt   = 0;
    logic [BW-1:0] olog [$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (mul_in_valid) start_cnt++;
            if (frame_err) err_cnt++;
            if (m_valid && m_ready) olog.push_back(m_data);
        end
    end

    bit stall_mode = 1'b0;
    int pidx = 0;
    logic [5:0] stall_pat = 6'b101001;

    always @(negedge clk) begin
        if (stall_mode) begin
            m_ready = stall_pat[pidx];
            pidx    = (pidx + 1) % 6;
        end
    end

    task automatic clear_log();
        start_cnt = 0;
        err_cnt   = 0;
        olog.delete();
    endtask

    task automatic send_word(input logic [BW-1:0] d, input logic l);
        int t;
        t = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) fail_timeout("s_ready_wait");
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [BW-1:0] px, input logic [BW-1:0] py,
                              input logic [BW-1:0] kl, input int last_pos,
                              input int nwords, input bit gap);
        logic [BW-1:0] d;
        for (int i = 0; i < nwords; i++) begin
            d = (i < W) ? px : (i < 2*W) ? py : (i == 2*W) ? kl : 32'h0;
            send_word(d, i == last_pos);
            if (gap) begin
                spur = (i == 10);
                @(negedge clk);
                spur = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) fail_timeout("idle_wait");
        repeat (2) @(negedge clk);
    endtask

    task automatic check_log(input string tag, input logic [BW-1:0] w0, input logic [BW-1:0] w7,
                             input logic [BW-1:0] w8, input logic [BW-1:0] w15);
        chk({tag, "_starts"}, start_cnt, 1);
        chk({tag, "_nwords"}, olog.size(), 16);
        if (olog.size() == 16) begin
            chk({tag, "_w0"}, olog[0], w0);
            chk({tag, "_w7"}, olog[7], w7);
            chk({tag, "_w8"}, olog[8], w8);
            chk({tag, "_w15"}, olog[15], w15);
        end
    endtask

    initial begin
        int t;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("post_rst_s_ready", s_ready, 1);

        // Nominal frame
        clear_log();
        send_frame(32'h11111111, 32'h22222222, 32'h00000001, 23, 24, 1'b0);
        wait_idle();
        check_log("nominal", 32'h11111112, 32'h11111111, 32'h22222223, 32'h22222222);
        chk("nominal_errs", err_cnt, 0);

        // Early last on word 5, then a good frame
        clear_log();
        send_frame(32'h33333333, 32'h44444444, 32'h5, 5, 6, 1'b0);
        repeat (3) @(negedge clk);
        chk("early_errs", err_cnt, 1);
        chk("early_starts", start_cnt, 0);
        clear_log();
        send_frame(32'hA5A5A5A5, 32'h0F0F0F0F, 32'h00000003, 23, 24, 1'b0);
        wait_idle();
        check_log("after_early", 32'hA5A5A5A6, 32'hA5A5A5A5, 32'h0F0F0F0C, 32'h0F0F0F0F);

        // Missing last on word 23
        clear_log();
        send_frame(32'h55555555, 32'h66666666, 32'h7, -1, 24, 1'b0);
        repeat (3) @(negedge clk);
        chk("missing_errs", err_cnt, 1);
        chk("missing_starts", start_cnt, 0);

        // Gapped input, spurious strobes in LOAD, stalled drain; Px+1 carries through all words
        clear_log();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        stall_mode = 1'b1;
        send_frame(32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 23, 24, 1'b1);
        wait_idle();
        stall_mode = 1'b0;
        m_ready    = 1'b1;
        check_log("stall", 32'h00000000, 32'h00000000, 32'hEDCBA987, 32'h12345678);
        chk("stall_errs", err_cnt, 0);

        // Reset while output word 7 is presented
        clear_log();
        send_frame(32'h01010101, 32'h02020202, 32'h00000004, 23, 24, 1'b0);
        t = 0;
        while (olog.size() < 7 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (olog.size() < 7) fail_timeout("word7_wait");
        rst_n = 1'b0;
        #1;
        chk("abort_m_valid", m_valid, 0);
        chk("abort_m_data", m_data, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        @(negedge clk);
        #1;
        chk("release_s_ready", s_ready, 1);
        chk("release_m_valid", m_valid, 0);
        repeat (20) @(negedge clk);
        chk("abort_no_start", start_cnt, 0);
        chk("abort_no_words", olog.size(), 0);
        send_frame(32'h11111111, 32'h22222222, 32'h00000001, 23, 24, 1'b0);
        wait_idle();
        check_log("after_abort", 32'h11111112, 32'h11111111, 32'h22222223, 32'h22222222);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
